// File: rtl/fetch_unit_if.sv
// Bundle of the fetch stage's external channels.
//   Instruction memory request : imem_req_valid/ready/addr
//   Instruction memory response: imem_resp_valid/data/err
//   Decoder channel            : ir_valid/ready, ir, ir_pc
//   Control                    : redirect_valid/pc in, fetch_fault out
// The master modport is the fetch unit; the slave modport is everything
// around it (memory, decoder, redirecting stages).
interface fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        imem_resp_err;
  logic        ir_valid;
  logic        ir_ready;
  logic [31:0] ir;
  logic [31:0] ir_pc;
  logic        fetch_fault;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport master (
    output imem_req_valid, imem_req_addr, ir_valid, ir, ir_pc, fetch_fault,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err,
           ir_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, ir_valid, ir, ir_pc, fetch_fault,
    output imem_req_ready, imem_resp_valid, imem_resp_data, imem_resp_err,
           ir_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage. Keeps the program counter, issues one word read
// at a time to instruction memory, captures the returned word into the
// instruction register and hands it to the decoder with valid/ready.
// Redirects from later stages always win; misaligned targets and bus
// errors park the unit in a fault state until the next redirect.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - fetch_unit_if.master: memory request/response, decoder ir
//           channel, redirect input and fetch_fault output
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_unit_if.master  bus
);

  typedef enum logic [2:0] {
    S_REQ,
    S_WAIT,
    S_DRAIN,
    S_FULL,
    S_FAULT
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] ir_q;
  logic [31:0] ir_pc_q;
  // Set when a misaligned redirect arrives while a response is still owed;
  // DRAIN then lands in FAULT instead of REQ.
  logic        pend_fault;

  logic        handshake;
  logic        owes_resp;
  logic        misaligned;

  assign bus.imem_req_valid = (state == S_REQ);
  assign bus.imem_req_addr  = pc;
  assign bus.ir_valid       = (state == S_FULL);
  assign bus.fetch_fault    = (state == S_FAULT);
  assign bus.ir             = ir_q;
  assign bus.ir_pc          = ir_pc_q;

  assign handshake  = (state == S_REQ) && bus.imem_req_ready;
  assign misaligned = (bus.redirect_pc[1:0] != 2'b00);

  // A redirect must not leave the memory with an orphaned response: if one
  // is accepted-but-not-yet-returned after this edge, go through DRAIN.
  always_comb begin
    owes_resp = 1'b0;
    case (state)
      S_REQ:   owes_resp = handshake;
      S_WAIT:  owes_resp = !bus.imem_resp_valid;
      S_DRAIN: owes_resp = !bus.imem_resp_valid;
      default: owes_resp = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_REQ;
      pc         <= RESET_PC;
      ir_q       <= 32'h0;
      ir_pc_q    <= 32'h0;
      pend_fault <= 1'b0;
    end else if (bus.redirect_valid) begin
      pc <= bus.redirect_pc;
      if (misaligned) begin
        ir_pc_q <= bus.redirect_pc;
        if (owes_resp) begin
          state      <= S_DRAIN;
          pend_fault <= 1'b1;
        end else begin
          state      <= S_FAULT;
          pend_fault <= 1'b0;
        end
      end else begin
        state      <= owes_resp ? S_DRAIN : S_REQ;
        pend_fault <= 1'b0;
      end
    end else begin
      case (state)
        S_REQ: begin
          if (handshake) state <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.imem_resp_valid) begin
            ir_pc_q <= pc;
            if (bus.imem_resp_err) begin
              state <= S_FAULT;
            end else begin
              ir_q  <= bus.imem_resp_data;
              pc    <= pc + 32'd4;
              state <= S_FULL;
            end
          end
        end
        S_DRAIN: begin
          if (bus.imem_resp_valid) begin
            state      <= pend_fault ? S_FAULT : S_REQ;
            pend_fault <= 1'b0;
          end
        end
        S_FULL: begin
          if (bus.ir_ready) state <= S_REQ;
        end
        S_FAULT: begin
          state <= S_FAULT;
        end
        default: state <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic clk;
  logic rst_n;
  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        rdv;
    logic [31:0] rdpc;
    logic        rdy;
    logic        rsv;
    logic [31:0] rsd;
    logic        rse;
    logic        irr;
    logic        e_rv;
    logic [31:0] e_addr;
    logic        e_irv;
    logic [31:0] e_ir;
    logic [31:0] e_irpc;
    logic        e_flt;
  } vec_t;

  vec_t vq[$];

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic rv, input logic [31:0] addr,
                            input logic irv, input logic [31:0] irw, input logic [31:0] irpc,
                            input logic flt);
    chk1 ({tag, ".req_valid"}, bus.imem_req_valid, rv);
    chk32({tag, ".req_addr"},  bus.imem_req_addr,  addr);
    chk1 ({tag, ".ir_valid"},  bus.ir_valid,       irv);
    chk32({tag, ".ir"},        bus.ir,             irw);
    chk32({tag, ".ir_pc"},     bus.ir_pc,          irpc);
    chk1 ({tag, ".fault"},     bus.fetch_fault,    flt);
  endtask

  task automatic drive(input logic rdv, input logic [31:0] rdpc, input logic rdy,
                       input logic rsv, input logic [31:0] rsd, input logic rse, input logic irr);
    bus.redirect_valid  = rdv;
    bus.redirect_pc     = rdpc;
    bus.imem_req_ready  = rdy;
    bus.imem_resp_valid = rsv;
    bus.imem_resp_data  = rsd;
    bus.imem_resp_err   = rse;
    bus.ir_ready        = irr;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Reference model: tracks the fetch as transactions (is a read in flight,
  // is it stale, is an instruction held, is the unit halted).
  logic [31:0] m_pc, m_ir, m_irpc;
  logic        m_out, m_stale, m_pend, m_have, m_fault;

  function automatic logic m_req();
    return !m_out && !m_have && !m_fault;
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_ir = 32'h0; m_irpc = 32'h0;
    m_out = 1'b0; m_stale = 1'b0; m_pend = 1'b0; m_have = 1'b0; m_fault = 1'b0;
  endtask

  task automatic model_step(input logic rdv, input logic [31:0] rdpc, input logic rdy,
                            input logic rsv, input logic [31:0] rsd, input logic rse,
                            input logic irr);
    logic hs, owes;
    hs = m_req() && rdy;
    if (rdv) begin
      owes    = hs || (m_out && !rsv);
      m_pc    = rdpc;
      m_have  = 1'b0;
      m_fault = 1'b0;
      m_out   = owes;
      m_stale = owes;
      if (rdpc[1:0] != 2'b00) begin
        m_irpc = rdpc;
        if (owes) m_pend = 1'b1;
        else begin
          m_pend  = 1'b0;
          m_fault = 1'b1;
        end
      end else begin
        m_pend = 1'b0;
      end
    end else if (hs) begin
      m_out   = 1'b1;
      m_stale = 1'b0;
    end else if (m_out && rsv) begin
      m_out = 1'b0;
      if (m_stale) begin
        m_fault = m_pend;
        m_pend  = 1'b0;
      end else if (rse) begin
        m_irpc  = m_pc;
        m_fault = 1'b1;
      end else begin
        m_ir   = rsd;
        m_irpc = m_pc;
        m_pc   = m_pc + 32'd4;
        m_have = 1'b1;
      end
    end else if (m_have && irr) begin
      m_have = 1'b0;
    end
  endtask

  initial begin
    int cnt;
    logic rdv, rdy, rsv, rse, irr;
    logic [31:0] rdpc, rsd;

    rst_n = 1'b0;
    idle();
    repeat (3) cyc();
    rst_n = 1'b1;

    // cycle-by-cycle vectors: expected outputs at cycle start, inputs for that cycle
    vq.push_back('{1'b0, 32'h0,   1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h0,   1'b0, 32'h0,         32'h0,   1'b0});
    vq.push_back('{1'b0, 32'h0,   1'b0, 1'b1, 32'h0000_2003, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,         32'h0,   1'b0});
    vq.push_back('{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 32'h4,   1'b1, 32'h0000_2003, 32'h0,   1'b0});
    vq.push_back('{1'b0, 32'h0,   1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h4,   1'b0, 32'h0000_2003, 32'h0,   1'b0});
    vq.push_back('{1'b0, 32'h0,   1'b0, 1'b1, 32'hAAAA_0001, 1'b0, 1'b0, 1'b0, 32'h4,   1'b0, 32'h0000_2003, 32'h0,   1'b0});
    vq.push_back('{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h8,   1'b1, 32'hAAAA_0001, 32'h4,   1'b0});
    vq.push_back('{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h8,   1'b1, 32'hAAAA_0001, 32'h4,   1'b0});
    vq.push_back('{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 32'h8,   1'b1, 32'hAAAA_0001, 32'h4,   1'b0});
    vq.push_back('{1'b0, 32'h0,   1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h8,   1'b0, 32'hAAAA_0001, 32'h4,   1'b0});
    vq.push_back('{1'b1, 32'h100, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h8,   1'b0, 32'hAAAA_0001, 32'h4,   1'b0});
    vq.push_back('{1'b0, 32'h0,   1'b0, 1'b1, 32'hBAD0_BAD0, 1'b0, 1'b1, 1'b0, 32'h100, 1'b0, 32'hAAAA_0001, 32'h4,   1'b0});
    vq.push_back('{1'b0, 32'h0,   1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h100, 1'b0, 32'hAAAA_0001, 32'h4,   1'b0});
    vq.push_back('{1'b0, 32'h0,   1'b0, 1'b1, 32'hCAFE_0000, 1'b1, 1'b0, 1'b0, 32'h100, 1'b0, 32'hAAAA_0001, 32'h4,   1'b0});
    vq.push_back('{1'b0, 32'h0,   1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 32'h100, 1'b0, 32'hAAAA_0001, 32'h100, 1'b1});
    vq.push_back('{1'b1, 32'h102, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h100, 1'b0, 32'hAAAA_0001, 32'h100, 1'b1});
    vq.push_back('{1'b1, 32'h80,  1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h102, 1'b0, 32'hAAAA_0001, 32'h102, 1'b1});
    vq.push_back('{1'b1, 32'h200, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h80,  1'b0, 32'hAAAA_0001, 32'h102, 1'b0});
    vq.push_back('{1'b1, 32'h202, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h200, 1'b0, 32'hAAAA_0001, 32'h102, 1'b0});
    vq.push_back('{1'b0, 32'h0,   1'b0, 1'b1, 32'h0,         1'b0, 1'b0, 1'b0, 32'h202, 1'b0, 32'hAAAA_0001, 32'h202, 1'b0});
    vq.push_back('{1'b1, 32'h300, 1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h202, 1'b0, 32'hAAAA_0001, 32'h202, 1'b1});
    vq.push_back('{1'b0, 32'h0,   1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h300, 1'b0, 32'hAAAA_0001, 32'h202, 1'b0});
    vq.push_back('{1'b1, 32'h400, 1'b0, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 32'h300, 1'b0, 32'hAAAA_0001, 32'h202, 1'b0});
    vq.push_back('{1'b0, 32'h0,   1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h400, 1'b0, 32'hAAAA_0001, 32'h202, 1'b0});
    vq.push_back('{1'b0, 32'h0,   1'b0, 1'b1, 32'h0000_0011, 1'b0, 1'b0, 1'b0, 32'h400, 1'b0, 32'hAAAA_0001, 32'h202, 1'b0});
    vq.push_back('{1'b1, 32'h500, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 32'h404, 1'b1, 32'h0000_0011, 32'h400, 1'b0});
    vq.push_back('{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h500, 1'b0, 32'h0000_0011, 32'h400, 1'b0});

    foreach (vq[i]) begin
      check_outs($sformatf("vec%0d", i), vq[i].e_rv, vq[i].e_addr, vq[i].e_irv,
                 vq[i].e_ir, vq[i].e_irpc, vq[i].e_flt);
      drive(vq[i].rdv, vq[i].rdpc, vq[i].rdy, vq[i].rsv, vq[i].rsd, vq[i].rse, vq[i].irr);
      cyc();
    end
    idle();

    // decoder stall in FULL for 5 cycles
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0); cyc();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'hDEAD_0003, 1'b0, 1'b0); cyc();
    idle();
    for (int k = 0; k < 5; k++) begin
      check_outs($sformatf("stall%0d", k), 1'b0, 32'h504, 1'b1, 32'hDEAD_0003, 32'h500, 1'b0);
      cyc();
    end
    bus.ir_ready = 1'b1; cyc(); idle();
    chk1 ("stall.release.req_valid", bus.imem_req_valid, 1'b1);
    chk32("stall.release.addr",      bus.imem_req_addr,  32'h504);

    // pc wrap at the top of the address space
    drive(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0); cyc(); idle();
    chk32("wrap.addr", bus.imem_req_addr, 32'hFFFF_FFFC);
    bus.imem_req_ready = 1'b1; cyc(); idle();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0005, 1'b0, 1'b0); cyc(); idle();
    chk32("wrap.ir_pc", bus.ir_pc, 32'hFFFF_FFFC);
    bus.ir_ready = 1'b1; cyc(); idle();
    chk1 ("wrap.req_valid", bus.imem_req_valid, 1'b1);
    chk32("wrap.next_addr", bus.imem_req_addr,  32'h0);

    // bus error holds the unit for 10 cycles until redirected
    drive(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0); cyc(); idle();
    bus.imem_req_ready = 1'b1; cyc(); idle();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0); cyc(); idle();
    for (int k = 0; k < 10; k++) begin
      bus.imem_req_ready = 1'b1;
      chk1 ($sformatf("err%0d.fault", k),     bus.fetch_fault,    1'b1);
      chk1 ($sformatf("err%0d.req_valid", k), bus.imem_req_valid, 1'b0);
      chk32($sformatf("err%0d.ir_pc", k),     bus.ir_pc,          32'h40);
      cyc();
    end
    drive(1'b1, 32'h80, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0); cyc(); idle();
    chk1 ("err.clear.fault",     bus.fetch_fault,    1'b0);
    chk1 ("err.clear.req_valid", bus.imem_req_valid, 1'b1);
    chk32("err.clear.addr",      bus.imem_req_addr,  32'h80);

    // misaligned redirect while waiting: drain, then fault on the late resp
    bus.imem_req_ready = 1'b1; cyc(); idle();
    drive(1'b1, 32'h102, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0); cyc(); idle();
    check_outs("misw.drain", 1'b0, 32'h102, 1'b0, 32'h0000_0005, 32'h102, 1'b0);
    bus.imem_resp_valid = 1'b1; cyc(); idle();
    check_outs("misw.fault", 1'b0, 32'h102, 1'b0, 32'h0000_0005, 32'h102, 1'b1);
    drive(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0); cyc(); idle();
    chk32("misw.recover.addr", bus.imem_req_addr, 32'h100);

    // asynchronous reset in the middle of WAIT
    bus.imem_req_ready = 1'b1; cyc(); idle();
    chk1("arst.in_wait", bus.imem_req_valid, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_outs("arst.now", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    cyc();
    rst_n = 1'b1;
    chk1 ("arst.release.req_valid", bus.imem_req_valid, 1'b1);
    chk32("arst.release.addr",      bus.imem_req_addr,  32'h0);

    // randomized traffic against the transaction-level model
    model_reset();
    cnt = 0;
    for (int n = 0; n < 3000; n++) begin
      check_outs($sformatf("rnd%0d", n), m_req(), m_pc, m_have, m_ir, m_irpc, m_fault);
      rsv = 1'b0; rsd = 32'h0; rse = 1'b0;
      if (cnt == 1) begin
        rsv = 1'b1;
        rsd = $urandom;
        rse = ($urandom_range(0, 15) == 0);
        cnt = 0;
      end else if (cnt > 1) begin
        cnt--;
      end
      rdy = ($urandom_range(0, 2) != 0);
      irr = ($urandom_range(0, 2) != 0);
      rdv = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 5) == 0) rdpc = 32'hFFFF_FFF0 + {28'h0, 2'($urandom_range(0, 3)), 2'b00};
      else                           rdpc = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      if ($urandom_range(0, 3) == 0) rdpc[1:0] = 2'($urandom_range(1, 3));
      drive(rdv, rdpc, rdy, rsv, rsd, rse, irr);
      if (bus.imem_req_valid && rdy) cnt = $urandom_range(1, 3);
      model_step(rdv, rdpc, rdy, rsv, rsd, rse, irr);
      cyc();
    end
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
